// File: rtl/hex_display_mux_if.sv
// Display-bus interface for hex_display_mux: the packed hex word and its load
// strobe travel toward the display; segments, digit selects and the frame
// pulse travel back. The master side feeds the display, the slave side is the
// display driver itself.
interface hex_display_mux_if #(
  parameter int N_DIGITS = 4
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   value;
  logic [6:0]              seg;
  logic [N_DIGITS-1:0]     an;
  logic                    frame_done;

  modport master (
    output load, value,
    input  seg, an, frame_done
  );

  modport slave (
    input  load, value,
    output seg, an, frame_done
  );
endinterface

// File: rtl/hex_display_mux.sv
// hex_display_mux: time-multiplexed driver for N_DIGITS common-select 7-segment
// digits. A packed hex word is captured into a pending register and promoted
// to the displayed word only at frame boundaries, so a frame never shows a mix
// of old and new digits. Digits are scanned round-robin, REFRESH_DIV cycles
// per slot, with the first BLANK_CYCLES of every slot dark to avoid ghosting.
// Outputs are registered (one cycle behind the scan state).
//
// Optional feature: define LEADING_ZERO_SUPPRESS_EN to keep leading-zero digits
// (k >= 1 whose nibble and all higher nibbles are zero) dark for their slot.
// Digit 0 is always shown. Scan timing does not change.
module hex_display_mux #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  hex_display_mux_if.slave   bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_CYCLES);

  // Scan position: cycle within the slot and the digit being driven.
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;

  // Pending word (last load) and the word the current frame is showing.
  logic [N_DIGITS-1:0][3:0]  pending;
  logic [N_DIGITS-1:0][3:0]  disp;

  logic                      slot_end;
  logic                      swap;
  logic                      blank;
  logic                      dark;
  logic [N_DIGITS-1:0]       lit;
  logic [6:0]                seg_next;
  logic [N_DIGITS-1:0]       an_next;

  // Hex nibble to {a,b,c,d,e,f,g}, active-high, a in bit 6.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  assign slot_end = (cnt == LAST_CNT);
  assign swap     = slot_end && (idx == LAST_IDX);

  // The blanking window collapses to nothing when BLANK_CYCLES is zero; the
  // split keeps an always-false unsigned compare out of the netlist.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign blank = 1'b0;
  end else begin : g_blank
    assign blank = (cnt < BLANK_C);
  end

`ifdef LEADING_ZERO_SUPPRESS_EN
  // A digit is lit if it or any more-significant digit is non-zero; digit 0 always lit.
  always_comb begin
    logic nz;
    nz  = 1'b0;
    lit = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      nz     = nz | (disp[k] != 4'h0);
      lit[k] = nz || (k == 0);
    end
  end
`else
  // Every digit is shown, leading zeros included.
  always_comb begin
    lit = '1;
  end
`endif

  assign dark = blank || !lit[idx];

  // Next segment/select pattern for the current scan position.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a
    // latch is inferred for the untouched bits.
    seg_next = '0;
    an_next  = '0;
    if (!dark) begin
      an_next[idx] = 1'b1;
      seg_next     = decode(disp[idx]);
    end
  end

  // Scan counters, word capture/swap and registered display outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values
    // (e.g. disp swaps using the pending value from before this edge's load).
    if (rst) begin
      cnt            <= '0;
      idx            <= '0;
      pending        <= '0;
      disp           <= '0;
      bus.seg        <= '0;
      bus.an         <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Last load wins; a load on the swap cycle also goes straight to disp.
      if (bus.load) begin
        pending <= bus.value;
      end
      if (swap) begin
        disp <= bus.load ? bus.value : pending;
      end

      bus.frame_done <= swap;
      bus.seg        <= seg_next;
      bus.an         <= an_next;
    end
  end

endmodule

// File: tb/tb_hex_display_mux.sv
// Self-checking bench for hex_display_mux (N_DIGITS=4, REFRESH_DIV=4,
// BLANK_CYCLES=1). A frame-level reference model tracks time since reset,
// the pending word and the displayed word, and predicts seg/an/frame_done
// for every cycle. Define LEADING_ZERO_SUPPRESS_EN for both RTL and bench to
// check the suppression variant.
module tb_hex_display_mux;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int BL    = 1;
  localparam int FRAME = ND * RD;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hex_display_mux_if #(.N_DIGITS(ND)) bus ();

  hex_display_mux #(
    .N_DIGITS    (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests  = 0;
  int failed = 0;

  // Reference model state.
  int          t;         // cycles since reset release (scan state before next edge)
  logic [15:0] m_pending;
  logic [15:0] m_disp;

  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s @t=%0d: got %h expected %h", tag, t, got, exp);
    end
  endtask

  // One clock cycle with the given load/value, checked against the model.
  task automatic cycle(input logic ld, input logic [15:0] val);
    int          pos, slot, sub;
    logic        dk;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_fd;
    bus.load  = ld;
    bus.value = val;
    pos  = t % FRAME;
    slot = pos / RD;
    sub  = pos % RD;
    dk   = (sub < BL);
`ifdef LEADING_ZERO_SUPPRESS_EN
    if (slot > 0 && (m_disp >> (4 * slot)) == 16'h0) dk = 1'b1;
`endif
    e_seg = dk ? 7'h00 : seg_tab[(m_disp >> (4 * slot)) & 16'hF];
    e_an  = dk ? 4'b0000 : 4'(1 << slot);
    e_fd  = (pos == FRAME - 1);
    if (pos == FRAME - 1) m_disp = ld ? val : m_pending;
    if (ld) m_pending = val;
    t++;
    @(posedge clk);
    #1;
    check("seg", 32'(bus.seg), 32'(e_seg));
    check("an", 32'(bus.an), 32'(e_an));
    check("frame_done", 32'(bus.frame_done), 32'(e_fd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0);
  endtask

  // Idle until the model's frame position equals p (at most one frame).
  task automatic advance_to(input int p);
    for (int i = 0; i < FRAME && (t % FRAME) != p; i++) cycle(1'b0, 16'h0);
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    bus.load = 1'b1;           // must be ignored while in reset
    bus.value = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("rst_seg", 32'(bus.seg), 32'h0);
      check("rst_an", 32'(bus.an), 32'h0);
      check("rst_fd", 32'(bus.frame_done), 32'h0);
    end
    rst       = 1'b0;
    bus.load  = 1'b0;
    t         = 0;
    m_pending = '0;
    m_disp    = '0;
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    rst       = 1'b1;
    bus.load  = 1'b0;
    bus.value = '0;
    t         = 0;
    m_pending = '0;
    m_disp    = '0;

    // Reset and idle scan showing zeros.
    do_reset(3);
    run(2 * FRAME);

    // Every nibble value on every digit position.
    for (int n = 0; n < 16; n++) begin
      v = '0;
      for (int k = 0; k < ND; k++) v[4*k +: 4] = 4'((n + k) % 16);
      cycle(1'b1, v);
      run(2 * FRAME);
    end

    // Mid-frame load at digit 1: old word until swap, then 33,79,6D,30.
    advance_to(RD + 1);
    cycle(1'b1, 16'h1234);
    run(2 * FRAME);

    // Load exactly on the swap cycle bypasses pending.
    advance_to(FRAME - 1);
    cycle(1'b1, 16'hABCD);
    run(FRAME + 2);

    // Multiple loads in one frame: last one wins.
    cycle(1'b1, 16'h1111);
    cycle(1'b1, 16'h2222);
    cycle(1'b1, 16'h0070);
    run(2 * FRAME);
    cycle(1'b1, 16'h0000);
    run(2 * FRAME);

    // Randomized loads, often with zero high nibbles.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        v = 16'($urandom) & masks[$urandom_range(0, 4)];
        cycle(1'b1, v);
      end else begin
        cycle(1'b0, 16'($urandom));
      end
    end

    // Reset mid-scan at digit 2, cycle 2.
    cycle(1'b1, 16'h9876);
    run(FRAME);
    advance_to(2 * RD + 2);
    do_reset(1);
    run(2 * FRAME);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
